// File: rtl/query_frame_tx_pkg.sv
// Shared definitions for the Gen2 reader command framers.
// Holds command codes, Query field layout, frame widths, the framer state
// encoding and the CRC5 preset/polynomial.
package query_frame_tx_pkg;

  localparam int unsigned CMD_CODE_W = 4;
  localparam int unsigned FIELD_W    = 13;
  localparam int unsigned CMD_W      = CMD_CODE_W + FIELD_W;  // 17
  localparam int unsigned CRC_W      = 5;
  localparam int unsigned FRAME_W    = CMD_W + CRC_W;         // 22
  localparam int unsigned CNT_W      = 5;

  // Command codes (QueryRep/QueryAdj are for later framers)
  localparam logic [3:0] CMD_QUERY    = 4'b1000;
  localparam logic [1:0] CMD_QUERYREP = 2'b00;
  localparam logic [3:0] CMD_QUERYADJ = 4'b1001;

  // Bit offsets (LSB) of each Query field inside the 13-bit field word
  localparam int unsigned OFS_Q       = 0;
  localparam int unsigned OFS_TARGET  = 4;
  localparam int unsigned OFS_SESSION = 5;
  localparam int unsigned OFS_SEL     = 7;
  localparam int unsigned OFS_TREXT   = 9;
  localparam int unsigned OFS_M       = 10;
  localparam int unsigned OFS_DR      = 12;

  // CRC5 = x^5 + x^3 + 1, preset 01001, not inverted
  localparam logic [CRC_W-1:0] CRC5_PRESET = 5'b01001;
  localparam logic [CRC_W-1:0] CRC5_POLY   = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_CRC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Query field word, MSB first as transmitted
  typedef struct packed {
    logic       dr;
    logic [1:0] m;
    logic       trext;
    logic [1:0] sel;
    logic [1:0] session;
    logic       target;
    logic [3:0] q;
  } query_fields_t;

endpackage

// File: rtl/crc5.sv
// Bit-serial Gen2 CRC5 generator/checker.
// Ports: clk; clr (sync, active-high, loads PRESET); in_dat/in_vld (one
// message bit per cycle when in_vld); crc (running register; reads zero
// after a frame with its own CRC appended has been fed through).
module crc5
  import query_frame_tx_pkg::*;
#(
  parameter logic [CRC_W-1:0] PRESET = CRC5_PRESET,
  parameter logic [CRC_W-1:0] POLY   = CRC5_POLY
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_dat,
  input  logic             in_vld,
  output logic [CRC_W-1:0] crc
);

  logic fb_c;

  assign fb_c = crc[CRC_W-1] ^ in_dat;

  // MSB-first LFSR; clear has priority over data
  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= PRESET;
    end else if (in_vld) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);
    end
  end

endmodule

// File: rtl/query_frame_tx.sv
// EPC Gen2 Query frame serializer: {command code, 13 field bits, CRC5},
// streamed MSB first, one bit per out_vld/out_rdy handshake.
// Ports: clk, rst (async, active-low); start (sampled in IDLE only);
// dr, m, trext, sel, session, target, q (Query fields, latched at start);
// out_dat/out_vld/out_rdy (bit stream to the PIE encoder);
// busy (start acceptance through the done pulse); done (frame complete).
module query_frame_tx
  import query_frame_tx_pkg::*;
#(
  parameter logic [CMD_CODE_W-1:0] CMD_CODE = CMD_QUERY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dr,
  input  logic [1:0] m,
  input  logic       trext,
  input  logic [1:0] sel,
  input  logic [1:0] session,
  input  logic       target,
  input  logic [3:0] q,
  output logic       out_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       busy,
  output logic       done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CMD_W-1:0]   cmd_sr, cmd_sr_nxt;
  logic [CRC_W-1:0]   crc_sr, crc_sr_nxt;
  logic               out_dat_nxt, out_vld_nxt, busy_nxt, done_nxt;

  query_fields_t      fields_c;
  logic [CMD_W-1:0]   cmd_word_c;
  logic               start_acc_c;
  logic               xfer_c;
  logic               crc_in_vld_c;
  logic               crc_clr_c;
  logic [CRC_W-1:0]   crc_val;

  assign fields_c    = query_fields_t'({dr, m, trext, sel, session, target, q});
  assign cmd_word_c  = {CMD_CODE, fields_c};
  assign start_acc_c = (state == ST_IDLE) && start;
  assign xfer_c      = out_vld && out_rdy;
  // Held in clear throughout reset so every frame starts from the preset
  assign crc_clr_c   = start_acc_c || !rst;

  crc5 u_crc5 (
    .clk    (clk),
    .clr    (crc_clr_c),
    .in_dat (out_dat),
    .in_vld (crc_in_vld_c),
    .crc    (crc_val)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      crc_sr  <= '0;
      out_dat <= 1'b0;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cmd_sr  <= cmd_sr_nxt;
      crc_sr  <= crc_sr_nxt;
      out_dat <= out_dat_nxt;
      out_vld <= out_vld_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next state, datapath and output values. Shift registers rotate rather
  // than shift so the latched word stays whole; only the MSB is ever sent.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cmd_sr_nxt   = cmd_sr;
    crc_sr_nxt   = crc_sr;
    out_dat_nxt  = out_dat;
    out_vld_nxt  = out_vld;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    crc_in_vld_c = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt   = ST_CMD;
          cnt_nxt     = '0;
          cmd_sr_nxt  = cmd_word_c;
          out_dat_nxt = cmd_word_c[CMD_W-1];
          out_vld_nxt = 1'b1;
          busy_nxt    = 1'b1;
        end
      end

      ST_CMD: begin
        if (!out_vld) begin
          // Bubble cycle: CRC register now holds the final value
          state_nxt   = ST_CRC;
          cnt_nxt     = '0;
          crc_sr_nxt  = crc_val;
          out_dat_nxt = crc_val[CRC_W-1];
          out_vld_nxt = 1'b1;
        end else if (xfer_c) begin
          crc_in_vld_c = 1'b1;
          cmd_sr_nxt   = {cmd_sr[CMD_W-2:0], cmd_sr[CMD_W-1]};
          if (cnt == CNT_W'(CMD_W - 1)) begin
            out_vld_nxt = 1'b0;
            out_dat_nxt = 1'b0;
          end else begin
            cnt_nxt     = cnt + CNT_W'(1);
            out_dat_nxt = cmd_sr[CMD_W-2];
          end
        end
      end

      ST_CRC: begin
        if (xfer_c) begin
          crc_sr_nxt = {crc_sr[CRC_W-2:0], crc_sr[CRC_W-1]};
          if (cnt == CNT_W'(CRC_W - 1)) begin
            state_nxt   = ST_DONE;
            cnt_nxt     = '0;
            out_vld_nxt = 1'b0;
            out_dat_nxt = 1'b0;
          end else begin
            cnt_nxt     = cnt + CNT_W'(1);
            out_dat_nxt = crc_sr[CRC_W-2];
          end
        end
      end

      ST_DONE: begin
        // done shows in the following (IDLE) cycle, busy drops after it
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_query_frame_tx.sv
// Randomized scoreboard bench for query_frame_tx: a driver issues Query
// frames and pushes the reference frame bits; a negedge monitor pops and
// compares each transferred bit, and checks stalls, done and CRC residue.
module tb_query_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dr = 1'b0, trext = 1'b0, target = 1'b0;
  logic [1:0] m = '0, sel = '0, session = '0;
  logic [3:0] q = '0;
  logic       out_rdy = 1'b0;
  logic       out_dat, out_vld, busy, done;

  int         n_chk = 0;
  int         n_fail = 0;
  bit         exp_q[$];
  int         rx_bits = 0;
  logic [21:0] rx_frame = '0;
  int         done_cnt = 0;
  int         exp_done = 0;
  bit         rdy_rand = 1'b0;
  bit         prev_stall = 1'b0;
  bit         prev_done = 1'b0;
  logic       prev_dat = 1'b0;

  always #5 clk = ~clk;

  query_frame_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dr      (dr),
    .m       (m),
    .trext   (trext),
    .sel     (sel),
    .session (session),
    .target  (target),
    .q       (q),
    .out_dat (out_dat),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference frame by polynomial long division; the preset is folded into
  // the leading five message bits.
  function automatic logic [21:0] model_frame(input logic [12:0] f);
    logic [16:0] msg;
    logic [21:0] v;
    msg = {4'b1000, f};
    v   = {msg ^ (17'(5'b01001) << 12), 5'b00000};
    for (int i = 21; i >= 5; i--)
      if (v[i]) v = v ^ (22'(6'b101001) << (i - 5));
    return {msg, v[4:0]};
  endfunction

  // Remainder of a received frame: zero for a frame carrying a good CRC
  function automatic logic [4:0] residue(input logic [21:0] fr);
    logic [21:0] v;
    v = fr ^ (22'(5'b01001) << 17);
    for (int i = 21; i >= 5; i--)
      if (v[i]) v = v ^ (22'(6'b101001) << (i - 5));
    return v[4:0];
  endfunction

  task automatic drive_start(input logic [12:0] f);
    logic [21:0] fr;
    {dr, m, trext, sel, session, target, q} = f;
    start = 1'b1;
    fr = model_frame(f);
    for (int i = 21; i >= 0; i--) exp_q.push_back(fr[i]);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_done();
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 32'(done_cnt), 32'(d0 + 1));
  endtask

  task automatic wait_bits(input int nb);
    int n;
    n = 0;
    while (rx_bits < nb && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (rx_bits < nb) check("bits_timeout", 32'(rx_bits), 32'(nb));
  endtask

  // Downstream ready: tied high or ~50% random
  initial begin
    forever begin
      @(posedge clk); #1;
      out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out_dat", 32'(out_dat), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        rx_bits    = 0;
      end else begin
        if (prev_stall) begin
          check("stall_vld", 32'(out_vld), 1);
          check("stall_dat", 32'(out_dat), 32'(prev_dat));
        end
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_bit: got bit %0b, required none (t=%0t)", out_dat, $time);
          end else begin
            check("frame_bit", 32'(out_dat), 32'(exp_q.pop_front()));
          end
          rx_frame = {rx_frame[20:0], out_dat};
          rx_bits++;
        end
        if (done) begin
          done_cnt++;
          check("done_width", 32'(prev_done), 0);
          check("bits_per_frame", 32'(rx_bits), 22);
          check("crc_residue", 32'(residue(rx_frame)), 0);
          check("busy_at_done", 32'(busy), 1);
          rx_bits = 0;
        end
        prev_stall = out_vld && !out_rdy;
        prev_dat   = out_dat;
        prev_done  = done;
      end
    end
  end

  initial begin
    int bc;
    logic [12:0] f;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // All-zero fields, ready tied high: known frame and busy length
    rdy_rand = 1'b0;
    drive_start(13'h0000);
    bc = 1;
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
      if (busy) bc++;
    end
    check("busy_cycles", 32'(bc), 25);
    check("zero_frame", 32'(rx_frame), 32'(22'b1000_0000000000000_10000));
    check("done_count_t1", 32'(done_cnt), 32'(exp_done));

    // Directed non-zero fields
    wait_idle();
    drive_start({1'b1, 2'b11, 1'b0, 2'b10, 2'b01, 1'b1, 4'b0100});
    wait_done();
    check("done_count_t2", 32'(done_cnt), 32'(exp_done));

    // Random fields with random stalls
    rdy_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_idle();
      drive_start(13'($urandom));
      wait_done();
    end
    check("done_count_t3", 32'(done_cnt), 32'(exp_done));

    // start re-asserted mid-frame with field changes
    rdy_rand = 1'b0;
    wait_idle();
    drive_start(13'($urandom));
    wait_bits(3);
    f = 13'($urandom);
    {dr, m, trext, sel, session, target, q} = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_bits(19);
    f = 13'($urandom);
    {dr, m, trext, sel, session, target, q} = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (4) @(posedge clk); #1;
    check("done_count_t4", 32'(done_cnt), 32'(exp_done));
    check("idle_after_t4", 32'(busy), 0);

    // Reset mid-frame, then a fresh frame under stalls
    wait_idle();
    drive_start(13'($urandom));
    wait_bits(10);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_done--;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    rdy_rand = 1'b1;
    @(posedge clk); #1;
    check("done_count_rst", 32'(done_cnt), 32'(exp_done));
    drive_start(13'($urandom));
    wait_done();
    check("done_count_t5", 32'(done_cnt), 32'(exp_done));

    // Back-to-back: second start in the done cycle
    rdy_rand = 1'b0;
    wait_idle();
    drive_start(13'($urandom));
    wait_done();
    drive_start(13'($urandom));
    @(negedge clk); #1;
    check("b2b_first_vld", 32'(out_vld), 1);
    check("b2b_busy", 32'(busy), 1);
    wait_done();
    wait_idle();
    check("done_count_t6", 32'(done_cnt), 32'(exp_done));
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
